// File: rtl/regwrite_arbiter_pkg.sv
// Shared widths and the write-request record passed between the arbiter and
// its output stage.
package regwrite_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic                  from_b;
    } wr_req_t;

endpackage

// File: rtl/regwrite_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on
// long-latency issue and cleared when that unit's result commits.
module regwrite_scoreboard
    import regwrite_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Set is applied after clear so a same-edge issue to a committing register wins.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard = busy[rs1] | busy[rs2];

endmodule

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has fixed priority
// over a long-latency unit (B), with a registered output and starvation stall.
module regwrite_arbiter
    import regwrite_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [XLEN-1:0]       b_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard,
    output logic                  stall_req,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] Write_register,
    output logic [XLEN-1:0]       Write_data
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    wr_req_t          next_req;
    wr_req_t          out_q;
    logic             b_fire;
    logic [CNT_W-1:0] starve_cnt;

    assign b_ready = !a_valid;
    assign b_fire  = b_valid & b_ready;

    always_comb begin
        next_req = '0;
        if (a_valid) begin
            next_req.valid  = 1'b1;
            next_req.rd     = a_rd;
            next_req.data   = a_data;
            next_req.from_b = 1'b0;
        end else if (b_fire) begin
            next_req.valid  = 1'b1;
            next_req.rd     = b_rd;
            next_req.data   = b_data;
            next_req.from_b = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= next_req;
        end
    end

    // Writes to x0 still occupy the output slot but never reach the register file.
    assign RegWrite       = out_q.valid && (out_q.rd != '0);
    assign Write_register = out_q.rd;
    assign Write_data     = out_q.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!b_valid || b_fire) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign stall_req = (starve_cnt == LIMIT);

    regwrite_scoreboard u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .set_en (issue_valid && (issue_rd != '0)),
        .set_rd (issue_rd),
        .clr_en (RegWrite && out_q.from_b),
        .clr_rd (out_q.rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .hazard (hazard)
    );

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: expected register-file writes are
// queued when stimulus is driven and popped one cycle later at the output.
module tb_regwrite_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic        stall_req;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;

    exp_t exp_q[$];
    exp_t exp_w;
    int   vectors    = 0;
    int   miscompares = 0;

    regwrite_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .a_valid        (a_valid),
        .a_rd           (a_rd),
        .a_data         (a_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_rd           (b_rd),
        .b_data         (b_data),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .hazard         (hazard),
        .stall_req      (stall_req),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hFFFF_FFFF;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd3; rs2 = 5'd0;
        step();
        step();
        vectors++;
        if (RegWrite !== 1'b0 || Write_register !== 5'd0 || Write_data !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_out: got we=%b rd=%0d data=%h, want 0/0/0", RegWrite, Write_register, Write_data);
        end
        vectors++;
        if (stall_req !== 1'b0 || hazard !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got stall=%b hazard=%b, want 0/0", stall_req, hazard);
        end
        vectors++;
        if (b_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_bready_a1: got %b, want 0", b_ready);
        end
        a_valid = 1'b0; issue_valid = 1'b0;
        #1;
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_bready_a0: got %b, want 1", b_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_a_only();
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1;
            a_rd    = (i == 0) ? 5'd5 : 5'($urandom_range(1, 31));
            a_data  = (i == 0) ? 32'h11 : $urandom;
            #1;
            vectors++;
            if (b_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL a_only_bready[%0d]: got %b, want 0", i, b_ready);
            end
            exp_q.push_back('{we: 1'b1, rd: a_rd, data: a_data});
            step();
            exp_w = exp_q.pop_front();
            vectors++;
            if (RegWrite !== exp_w.we || Write_register !== exp_w.rd || Write_data !== exp_w.data) begin
                miscompares++;
                $display("[TB] FAIL a_only_write[%0d]: got we=%b rd=%0d data=%h, want we=%b rd=%0d data=%h",
                         i, RegWrite, Write_register, Write_data, exp_w.we, exp_w.rd, exp_w.data);
            end
        end
        a_valid = 1'b0;
        step();
        vectors++;
        if (RegWrite !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL a_only_single_cycle: got we=%b, want 0", RegWrite);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd0;
        #1;
        vectors++;
        if (hazard !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sb_pending: got hazard=%b, want 1", hazard);
        end
        a_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hDEAD;
        #1;
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sb_bready: got %b, want 1", b_ready);
        end
        exp_q.push_back('{we: 1'b1, rd: 5'd7, data: 32'hDEAD});
        step();
        b_valid = 1'b0;
        exp_w = exp_q.pop_front();
        vectors++;
        if (RegWrite !== exp_w.we || Write_register !== exp_w.rd || Write_data !== exp_w.data) begin
            miscompares++;
            $display("[TB] FAIL sb_bwrite: got we=%b rd=%0d data=%h, want we=%b rd=%0d data=%h",
                     RegWrite, Write_register, Write_data, exp_w.we, exp_w.rd, exp_w.data);
        end
        vectors++;
        if (hazard !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sb_hazard_commit_cycle: got %b, want 1", hazard);
        end
        step();
        vectors++;
        if (hazard !== 1'b0 || RegWrite !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sb_hazard_cleared: got hazard=%b we=%b, want 0/0", hazard, RegWrite);
        end
    endtask

    task automatic test_collision();
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h0000_00B4;
        for (int c = 1; c <= 5; c++) begin
            a_valid = (c <= 3);
            a_rd    = 5'(c);
            a_data  = 32'hA000_0000 + 32'(c);
            if (c == 5) b_valid = 1'b0;
            #1;
            vectors++;
            if (b_ready !== (c > 3)) begin
                miscompares++;
                $display("[TB] FAIL coll_bready[%0d]: got %b, want %b", c, b_ready, (c > 3));
            end
            if (c <= 3) exp_q.push_back('{we: 1'b1, rd: a_rd, data: a_data});
            else if (c == 4) exp_q.push_back('{we: 1'b1, rd: 5'd4, data: 32'h0000_00B4});
            else exp_q.push_back('{we: 1'b0, rd: 5'd0, data: 32'd0});
            step();
            exp_w = exp_q.pop_front();
            vectors++;
            if (RegWrite !== exp_w.we || (exp_w.we && (Write_register !== exp_w.rd || Write_data !== exp_w.data))) begin
                miscompares++;
                $display("[TB] FAIL coll_write[%0d]: got we=%b rd=%0d data=%h, want we=%b rd=%0d data=%h",
                         c, RegWrite, Write_register, Write_data, exp_w.we, exp_w.rd, exp_w.data);
            end
        end
    endtask

    task automatic test_starvation();
        b_valid = 1'b1; b_rd = 5'd11; b_data = 32'hBBBB_0011;
        for (int c = 1; c <= 7; c++) begin
            a_valid = (c <= 6);
            a_rd    = 5'd10;
            a_data  = 32'hC0DE_0000 + 32'(c);
            #1;
            vectors++;
            if (stall_req !== (c >= 5)) begin
                miscompares++;
                $display("[TB] FAIL starve_stall[%0d]: got %b, want %b", c, stall_req, (c >= 5));
            end
            if (c <= 6) exp_q.push_back('{we: 1'b1, rd: 5'd10, data: a_data});
            else exp_q.push_back('{we: 1'b1, rd: 5'd11, data: 32'hBBBB_0011});
            step();
            if (c == 7) b_valid = 1'b0;
            exp_w = exp_q.pop_front();
            vectors++;
            if (RegWrite !== exp_w.we || Write_register !== exp_w.rd || Write_data !== exp_w.data) begin
                miscompares++;
                $display("[TB] FAIL starve_write[%0d]: got we=%b rd=%0d data=%h, want we=%b rd=%0d data=%h",
                         c, RegWrite, Write_register, Write_data, exp_w.we, exp_w.rd, exp_w.data);
            end
        end
        vectors++;
        if (stall_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL starve_release: got stall=%b, want 0", stall_req);
        end
    endtask

    task automatic test_x0_set_wins();
        a_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h55;
        #1;
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL x0_bready: got %b, want 1", b_ready);
        end
        step();
        b_valid = 1'b0;
        vectors++;
        if (RegWrite !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL x0_regwrite: got %b, want 0", RegWrite);
        end
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9999;
        step();
        b_valid = 1'b0;
        vectors++;
        if (RegWrite !== 1'b1 || Write_register !== 5'd9) begin
            miscompares++;
            $display("[TB] FAIL setwin_commit: got we=%b rd=%0d, want 1/9", RegWrite, Write_register);
        end
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0; rs1 = 5'd9; rs2 = 5'd0;
        #1;
        vectors++;
        if (hazard !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL setwin_busy9: got hazard=%b, want 1", hazard);
        end
    endtask

    task automatic test_reset_midflight();
        a_valid = 1'b1; a_rd = 5'd12; a_data = 32'h1212;
        step();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd13; b_data = 32'h1313;
        issue_valid = 1'b1; issue_rd = 5'd13; rs1 = 5'd9; rs2 = 5'd13;
        #1;
        vectors++;
        if (RegWrite !== 1'b1 || Write_register !== 5'd12 || b_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_before: got we=%b rd=%0d bready=%b, want 1/12/1", RegWrite, Write_register, b_ready);
        end
        step();
        vectors++;
        if (RegWrite !== 1'b0 || hazard !== 1'b0 || stall_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_after: got we=%b hazard=%b stall=%b, want 0/0/0", RegWrite, hazard, stall_req);
        end
        rst = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
        step();
        vectors++;
        if (RegWrite !== 1'b0 || hazard !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_quiet: got we=%b hazard=%b, want 0/0", RegWrite, hazard);
        end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_scoreboard();
        test_collision();
        test_starvation();
        test_x0_set_wins();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the count of consecutive cycles port B may wait before stall_req asserts (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a_valid  input  1  pipeline writeback (port A) write request; no ready, never back-pressured.
REQ-005 a_rd / a_data  input  5 / 32  port A destination register / data.
REQ-006 b_valid  input  1  long-latency unit (port B) write request.
REQ-007 b_ready  output  1  port B accept; transfer when b_valid & b_ready.
REQ-008 b_rd / b_data  input  5 / 32  port B destination register / data; held stable while b_valid & !b_ready.
REQ-009 issue_valid / issue_rd  input  1 / 5  long-latency op issued; marks issue_rd pending.
REQ-010 rs1 / rs2  input  5 / 5  source registers checked by the decode stage.
REQ-011 hazard  output  1  rs1 or rs2 is pending.
REQ-012 stall_req  output  1  request that the pipeline hold port A idle.
REQ-013 RegWrite / Write_register / Write_data  output  1 / 5 / 32  register file write port.

Function
REQ-014 Arbitration: fixed priority, A over B; b_ready = !a_valid, combinational.
REQ-015 Output stage is registered: an accepted write (A, or B transfer) appears on RegWrite/Write_register/Write_data the next cycle, for exactly one cycle; latency 1.
REQ-016 Any write with destination 0 is accepted (B handshake completes) but drives RegWrite = 0.
REQ-017 Scoreboard: 32-bit busy vector; bit 0 permanently 0.
REQ-018 issue_valid with issue_rd != 0 sets busy[issue_rd] at the clock edge.
REQ-019 busy[r] clears on the edge where the output stage drives RegWrite = 1 with Write_register = r from a B-originated write (the same edge the register file commits).
REQ-020 Simultaneous set and clear of the same register: set wins (busy stays 1).
REQ-021 A-originated writes never change busy.
REQ-022 hazard = busy[rs1] | busy[rs2], combinational from current state.
REQ-023 Starvation counter: increments each cycle b_valid & !b_ready, saturates at STARVE_LIMIT, clears on any B transfer or when b_valid = 0.
REQ-024 stall_req = 1 when counter == STARVE_LIMIT (registered state, so stall_req rises STARVE_LIMIT cycles after B first waits); drops the cycle after the B transfer.
REQ-025 If a_valid = 1 while stall_req = 1, A still wins (A write is never dropped); counter stays saturated.

Reset
REQ-026 On rst at posedge clk: busy = 0, counter = 0, RegWrite = 0, Write_register = 0, Write_data = 0, stall_req = 0.
REQ-027 Reset mid-operation discards any registered write in flight (RegWrite = 0 next cycle) and all pending marks; inputs ignored during the reset cycle.
REQ-028 b_ready and hazard remain combinational during reset (hazard = 0 since busy = 0 after the first reset edge).

Structure
REQ-029 Shared package holds REG_ADDR_W = 5, XLEN = 32, NUM_REGS = 32 and the write-request struct {valid, rd, data, from_b}.
REQ-030 One sub-module: regwrite_scoreboard (busy vector, set/clear, hazard lookup); arbitration, starvation counter and output stage stay in the top.

Verification
REQ-031 A only: a_valid=1, a_rd=5, a_data=0x11 -> next cycle RegWrite=1, Write_register=5, Write_data=0x11; b_ready=0 that cycle.
REQ-032 Scoreboard: issue_rd=7; then B writes rd=7, data=0xDEAD with a_valid=0 -> hazard(rs1=7)=1 until the edge where RegWrite=1/Write_register=7, hazard=0 the following cycle.
REQ-033 Collision: a_valid and b_valid both 1 for 3 cycles, then a_valid=0 -> A writes in order, B transfers on cycle 4, its write on cycle 5; b_data held stable throughout.
REQ-034 Starvation: STARVE_LIMIT=4, a_valid=1 and b_valid=1 continuously -> stall_req=1 from cycle 5; drop a_valid -> B transfers, stall_req=0 next cycle.
REQ-035 x0 and set-wins: B write rd=0 -> handshake completes, RegWrite=0; issue_rd=9 on the same edge as a B write to 9 commits -> busy[9] remains 1.
REQ-036 Reset mid-flight: assert rst the cycle after an A acceptance -> RegWrite=0, hazard=0, stall_req=0 next cycle.
